// File: rtl/reset_sequencer.sv
// Core reset sequencer: asserts core_rst_n asynchronously on rst, releases it
// synchronously after a synchronizer plus programmable hold, and services soft resets.
module reset_sequencer #(
    parameter int SYNC_STAGES      = 2,
    parameter int HOLD_CYCLES      = 4,
    parameter int SOFT_HOLD_CYCLES = 3,
    parameter int CNT_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst_req,
    output logic             core_rst_n,
    output logic             core_ready,
    output logic             soft_rst_ack,
    output logic [CNT_W-1:0] soft_rst_count
);

    localparam int MAX_HOLD = (HOLD_CYCLES > SOFT_HOLD_CYCLES) ? HOLD_CYCLES : SOFT_HOLD_CYCLES;
    localparam int CW       = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RUN,
        ST_SOFT
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               rel_sync;

    assign rel_sync = ~sync_q[SYNC_STAGES-1];

    // NOTE: every sequential register uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b0};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        unique case (state_q)
            ST_ASSERT: begin
                // Leave on the edge that loads the released level into the last stage.
                if (rel_sync || !sync_q[SYNC_STAGES-2]) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = ST_RUN;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            ST_RUN: begin
                if (soft_rst_req) begin
                    state_d = ST_SOFT;
                    cnt_d   = '0;
                    if (count_q != '1) count_d = count_q + 1'b1;
                end
            end
            ST_SOFT: begin
                if (cnt_q == CW'(SOFT_HOLD_CYCLES - 1)) state_d = ST_RUN;
                else                                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_ASSERT;
        endcase
    end

    // The counter is zero in SOFT only during the first cycle after acceptance.
    assign core_rst_n     = (state_q == ST_RUN);
    assign core_ready     = (state_q == ST_RUN);
    assign soft_rst_ack   = (state_q == ST_SOFT) && (cnt_q == '0);
    assign soft_rst_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer: a countdown model of "cycles left low"
// predicts core_rst_n, core_ready, ack and the saturating counts of two instances.
module tb_reset_sequencer;

    localparam int SYNC  = 2;
    localparam int HOLD  = 4;
    localparam int SHOLD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_rst_req = 1'b0;

    logic       core_rst_n_a, core_ready_a, soft_rst_ack_a;
    logic [7:0] soft_rst_count_a;
    logic       core_rst_n_b, core_ready_b, soft_rst_ack_b;
    logic [1:0] soft_rst_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .SOFT_HOLD_CYCLES(SHOLD), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req),
        .core_rst_n(core_rst_n_a), .core_ready(core_ready_a),
        .soft_rst_ack(soft_rst_ack_a), .soft_rst_count(soft_rst_count_a)
    );

    reset_sequencer #(
        .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .SOFT_HOLD_CYCLES(SHOLD), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req),
        .core_rst_n(core_rst_n_b), .core_ready(core_ready_b),
        .soft_rst_ack(soft_rst_ack_b), .soft_rst_count(soft_rst_count_b)
    );

    // Reference: number of edges remaining before the core leaves reset.
    int low_left = SYNC + HOLD;
    int ack_exp  = 0;
    int cnt_a    = 0;
    int cnt_b    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            low_left <= SYNC + HOLD;
            ack_exp  <= 0;
            cnt_a    <= 0;
            cnt_b    <= 0;
        end else if (low_left == 0 && soft_rst_req) begin
            low_left <= SHOLD;
            ack_exp  <= 1;
            cnt_a    <= (cnt_a < 255) ? cnt_a + 1 : cnt_a;
            cnt_b    <= (cnt_b < 3) ? cnt_b + 1 : cnt_b;
        end else begin
            ack_exp  <= 0;
            if (low_left > 0) low_left <= low_left - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int run_exp;
        run_exp = (low_left == 0) ? 1 : 0;
        check("core_rst_n_a", 32'(core_rst_n_a), run_exp);
        check("core_ready_a", 32'(core_ready_a), run_exp);
        check("ack_a", 32'(soft_rst_ack_a), ack_exp);
        check("count_a", 32'(soft_rst_count_a), cnt_a);
        check("core_rst_n_b", 32'(core_rst_n_b), run_exp);
        check("ack_b", 32'(soft_rst_ack_b), ack_exp);
        check("count_b", 32'(soft_rst_count_b), cnt_b);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rst_n"}, 32'(core_rst_n_a), 0);
        check({tag, "_ready"}, 32'(core_ready_a), 0);
        check({tag, "_ack"}, 32'(soft_rst_ack_a), 0);
        check({tag, "_count_a"}, 32'(soft_rst_count_a), 0);
        check({tag, "_count_b"}, 32'(soft_rst_count_b), 0);
    endtask

    // Apply a request level for one cycle, then check just after the following negedge.
    task automatic tick(input bit req);
        soft_rst_req = req;
        @(negedge clk);
        check_outputs();
    endtask

    // Called aligned to a negedge; cycles==0 is a glitch shorter than one clock.
    task automatic pulse_rst(input int cycles);
        #1 rst = 1'b1;
        #1 check_reset_values("async_rst");
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_reset_values("held_rst");
        end
        #1 rst = 1'b0;
    endtask

    initial begin
        // Power-on reset held for three cycles, released mid-cycle.
        repeat (3) begin
            @(negedge clk);
            check_reset_values("por");
        end
        #2 rst = 1'b0;
        repeat (8) tick(1'b0);

        // Single-cycle soft request.
        tick(1'b1);
        repeat (6) tick(1'b0);

        // Request held high: back-to-back soft resets.
        repeat (20) tick(1'b1);
        repeat (3) tick(1'b0);

        // rst during the second SOFT cycle.
        tick(1'b1);
        tick(1'b0);
        pulse_rst(2);

        // Request raised only while in HOLD.
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        repeat (4) tick(1'b0);

        // Five accepted soft resets from a cleared count.
        pulse_rst(1);
        repeat (7) tick(1'b0);
        repeat (5) begin
            tick(1'b1);
            repeat (3) tick(1'b0);
        end

        // Random requests of varying density with occasional resets and glitches.
        for (int blk = 0; blk < 5; blk++) begin
            int dens;
            dens = int'($urandom_range(5, 95));
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 79) == 0) pulse_rst(int'($urandom_range(0, 2)));
                else tick($urandom_range(0, 99) < dens);
            end
        end
        tick(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
